data_memory_responder: RTL and testbench

- Word-addressed data memory that services the S-Machine CPU's LD/ST memory port. It is the responder end of that port.
- Accepts single-word read or write requests and models a configurable number of wait states. Returns read data with an acknowledge pulse.
- Sits between the CPU's memory interface and the on-chip data store. The CPU's read_write_memory/addr/data_out_memory drive this block; its data_in_memory feeds the CPU.

---
 rtl/data_memory_if.sv | 25 ++
 rtl/data_memory_responder.sv | 143 ++++++++++++++
 tb/tb_data_memory_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Memory port between the S-Machine CPU (master) and the data memory
// responder (slave). One request/acknowledge handshake per single-word access.
interface data_memory_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              req;
  logic              read_write_memory;   // 0 = read, 1 = write
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out_memory;     // CPU -> memory
  logic [DATA_W-1:0] data_in_memory;      // memory -> CPU
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, read_write_memory, addr, data_out_memory,
    input  data_in_memory, ack, busy, err
  );

  modport slave (
    input  req, read_write_memory, addr, data_out_memory,
    output data_in_memory, ack, busy, err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering the CPU's LD/ST port.
// A request is latched in IDLE, held for WAIT_STATES cycles, and completed with
// a one-cycle ack in RESP. Array writes and read-data loads happen on the edge
// that enters RESP, so an abort before that edge commits nothing.
// Optional feature: define DATA_MEMORY_WRITE_PROTECT_EN to make addresses
// 0..PROTECT_TOP read-only (writes there complete but raise err).
module data_memory_responder #(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = 9'h00F
) (
  input  logic           clk,
  input  logic           reset_n,
  data_memory_if.slave   bus
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              rw_reg, rw_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              busy_reg, busy_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              enter_resp;
  logic              in_protect;
  logic              mem_we;
  logic              rd_load;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DATA_MEMORY_WRITE_PROTECT_EN
  assign in_protect = (addr_next <= PROTECT_TOP);
`else
  // Protection compiled out: every address is writable.
  logic unused_protect_top;
  assign unused_protect_top = &{1'b0, PROTECT_TOP};
  assign in_protect = 1'b0;
`endif

  // Next-state logic; the latched request fields are taken from *_next so a
  // zero-wait-state access can use the inputs on its accepting edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    wdata_next = wdata_reg;
    busy_next  = 1'b0;
    ack_next   = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          addr_next  = bus.addr;
          rw_next    = bus.read_write_memory;
          wdata_next = bus.data_out_memory;
          busy_next  = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
            ack_next   = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WS_INIT;
          end
        end
      end
      WAIT: begin
        busy_next = 1'b1;
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
          ack_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_we   = enter_resp & rw_next & ~in_protect;
  assign rd_load  = enter_resp & ~rw_next;
  assign err_next = enter_resp & rw_next & in_protect;

  // State, request latch and registered outputs; async reset aborts any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      rw_reg    <= 1'b0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      rw_reg    <= rw_next;
      wdata_reg <= wdata_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
    end
  end

  // Read data register: loaded only on a read's RESP-entry edge, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg <= '0;
    end else if (rd_load) begin
      rdata_reg <= mem[addr_next];
    end
  end

  // Storage array write port (contents are not reset).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_next] <= wdata_next;
    end
  end

  assign bus.data_in_memory = rdata_reg;
  assign bus.ack            = ack_reg;
  assign bus.busy           = busy_reg;
  assign bus.err            = err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states
// and one with zero wait states share the clock and reset.
module tb_data_memory_responder;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  data_memory_if #(.ADDR_W(9), .DATA_W(16)) bus0 ();
  data_memory_if #(.ADDR_W(9), .DATA_W(16)) bus2 ();

  data_memory_responder #(
    .ADDR_W(9), .DATA_W(16), .WAIT_STATES(0), .PROTECT_TOP(9'h00F)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  data_memory_responder #(
    .ADDR_W(9), .DATA_W(16), .WAIT_STATES(2), .PROTECT_TOP(9'h00F)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic wr,
                       input logic [8:0] a, input logic [15:0] d);
    if (sel == 0) begin
      bus0.req = r; bus0.read_write_memory = wr; bus0.addr = a; bus0.data_out_memory = d;
    end else begin
      bus2.req = r; bus2.read_write_memory = wr; bus2.addr = a; bus2.data_out_memory = d;
    end
  endtask

  // {busy, ack, err, data_in_memory}
  function automatic logic [18:0] outs(input int sel);
    if (sel == 0) return {bus0.busy, bus0.ack, bus0.err, bus0.data_in_memory};
    return {bus2.busy, bus2.ack, bus2.err, bus2.data_in_memory};
  endfunction

  // One transaction; request fields are scrambled right after acceptance so
  // the DUT must use its latched copy.
  task automatic txn(input int sel, input logic wr, input logic [8:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output int lat, output int busy_n,
                     output logic err_seen);
    logic [18:0] o;
    bit got;
    got = 0; lat = 0; busy_n = 0; err_seen = 1'b0; rd = 16'h0;
    @(negedge clk);
    drive(sel, 1'b1, wr, a, d);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      o = outs(sel);
      if (lat == 1) drive(sel, 1'b0, ~wr, ~a, ~d);
      if (o[18]) busy_n++;
      if (o[17]) begin
        got = 1;
        err_seen = o[16];
        rd = o[15:0];
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    $display("txn dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d busy=%0d err=%0d",
             sel == 0 ? 0 : 2, wr ? "WR" : "RD", a, d, rd, lat, busy_n, err_seen);
  endtask

  logic [15:0] rd;
  logic [15:0] prior;
  int          lat;
  int          bn;
  logic        e;
  logic [18:0] o;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    drive(0, 1'b0, 1'b0, 9'h0, 16'h0);
    drive(2, 1'b0, 1'b0, 9'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("reset_outs_ws0", 32'(outs(0)), 32'd0);
    check("reset_outs_ws2", 32'(outs(2)), 32'd0);
    reset_n = 1'b1;

    // Preloads on the two-wait-state instance
    txn(2, 1'b1, 9'h020, 16'h0000, rd, lat, bn, e);
    txn(2, 1'b1, 9'h000, 16'h00FF, rd, lat, bn, e);

    // Latency with two wait states
    txn(2, 1'b1, 9'h1FF, 16'h1234, rd, lat, bn, e);
    check("ws2_wr_latency", 32'(lat), 32'd3);
    check("ws2_wr_busy_cycles", 32'(bn), 32'd3);
    check("ws2_wr_err", 32'(e), 32'd0);
    txn(2, 1'b0, 9'h1FF, 16'h0000, rd, lat, bn, e);
    check("ws2_rd_latency", 32'(lat), 32'd3);
    check("ws2_rd_busy_cycles", 32'(bn), 32'd3);
    check("ws2_rd_data", 32'(rd), 32'h1234);

    // Data hold across a write
    txn(2, 1'b0, 9'h000, 16'h0000, rd, lat, bn, e);
    check("hold_rd_data", 32'(rd), 32'h00FF);
    txn(2, 1'b1, 9'h001, 16'h7777, rd, lat, bn, e);
    check("hold_at_wr_ack", 32'(rd), 32'h00FF);
    @(negedge clk);
    check("hold_after_wr_ack", 32'(outs(2)), {3'b000, 16'h00FF});
    txn(2, 1'b0, 9'h001, 16'h0000, rd, lat, bn, e);
    check("latched_wdata", 32'(rd), 32'h7777);

    // Held request with a moving address: period 4, own sampled address
    for (int i = 0; i < 12; i++) begin
      txn(2, 1'b1, 9'(9'h040 + i), 16'(16'h5040 + i), rd, lat, bn, e);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      o = outs(2);
      check($sformatf("held_ack_%0d", n), 32'(o[17]), 32'((n % 4) == 3));
      if ((n % 4) == 3) begin
        check($sformatf("held_data_%0d", n), 32'(o[15:0]), 32'(16'h5040 + n - 3));
        $display("held read cycle=%0d data=%h", n, o[15:0]);
      end
      drive(2, 1'b1, 1'b0, 9'(9'h040 + n), 16'h0);
    end
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 9'h0, 16'h0);
    repeat (6) @(negedge clk);

    // Reset in the middle of WAIT of a write
    drive(2, 1'b1, 1'b1, 9'h020, 16'hBEEF);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 9'h0, 16'h0);
    check("pre_reset_busy", 32'(outs(2) >> 18), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midwait_reset_outs", 32'(outs(2)), 32'd0);
    $display("reset asserted mid-WAIT of write 020<=BEEF");
    @(negedge clk);
    reset_n = 1'b1;
    txn(2, 1'b1, 9'h021, 16'h0001, rd, lat, bn, e);
    txn(2, 1'b0, 9'h020, 16'h0000, rd, lat, bn, e);
    check("aborted_write_not_committed", 32'(rd), 32'h0000);

    // Zero wait states, back-to-back write then read
    txn(0, 1'b1, 9'h010, 16'hA5A5, rd, lat, bn, e);
    check("ws0_wr_latency", 32'(lat), 32'd1);
    check("ws0_wr_busy_cycles", 32'(bn), 32'd1);
    txn(0, 1'b0, 9'h010, 16'h0000, rd, lat, bn, e);
    check("ws0_rd_latency", 32'(lat), 32'd1);
    check("ws0_rd_data", 32'(rd), 32'hA5A5);

`ifdef DATA_MEMORY_WRITE_PROTECT_EN
    txn(0, 1'b0, 9'h00F, 16'h0000, prior, lat, bn, e);
    check("prot_rd_err", 32'(e), 32'd0);
    txn(0, 1'b1, 9'h00F, 16'hDEAD, rd, lat, bn, e);
    check("prot_wr_latency", 32'(lat), 32'd1);
    check("prot_wr_err", 32'(e), 32'd1);
    txn(0, 1'b0, 9'h00F, 16'h0000, rd, lat, bn, e);
    check("prot_wr_not_stored", 32'(rd), 32'(prior));
    txn(0, 1'b1, 9'h010, 16'hDEAD, rd, lat, bn, e);
    check("unprot_wr_err", 32'(e), 32'd0);
    txn(0, 1'b0, 9'h010, 16'h0000, rd, lat, bn, e);
    check("unprot_wr_stored", 32'(rd), 32'hDEAD);
`else
    prior = 16'h0000;
    txn(0, 1'b1, 9'h00F, 16'hDEAD, rd, lat, bn, e);
    check("low_wr_err", 32'(e), 32'd0);
    txn(0, 1'b0, 9'h00F, 16'h0000, rd, lat, bn, e);
    check("low_wr_stored", 32'(rd), 32'hDEAD);
    check("low_rd_err", 32'(e), 32'(prior[0]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
